key_alu_sequencer: RTL

Sequences the arithmetic unit from the keypad command path. Each completed command arrives as operands SRC/DST, opcode ALU_OP and a `finish` level from the keypad input buffer. The block captures it on the rising edge of `finish`, issues one start pulse to the ALU and waits for its done handshake. It then publishes the registered result to the display side. A one-entry pending slot absorbs a command entered while the ALU is busy; a second one is dropped and flagged.

---
 rtl/key_alu_sequencer_pkg.sv | 22 ++
 rtl/key_alu_sequencer_cmd_slot.sv | 39 +++
 rtl/key_alu_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/key_alu_sequencer_pkg.sv
// Shared constants for the keypad-to-ALU command path: opcode width of the
// input interface, data width, sequencer state encodings and the result
// written when the ALU fails to answer.
package key_alu_sequencer_pkg;

    // Opcode width delivered by the keypad input buffer.
    localparam int unsigned IC_N = 4;

    // Operand / result width.
    localparam int unsigned DATA_W = 16;

    // Result published on an ALU timeout.
    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage : key_alu_sequencer_pkg

// File: rtl/key_alu_sequencer_cmd_slot.sv
// key_cmd_slot: one valid-flagged command register (operand A, operand B,
// opcode). Used as the single pending entry of key_alu_sequencer.
// Load takes priority over clear.
module key_cmd_slot
    import key_alu_sequencer_pkg::*;
#(
    parameter int unsigned OP_W = IC_N
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [OP_W-1:0]   op_in,
    output logic              valid,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op
);

    // Hold a command until the sequencer consumes it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            op    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            a     <= a_in;
            b     <= b_in;
            op    <= op_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule : key_cmd_slot

// File: rtl/key_alu_sequencer.sv
// key_alu_sequencer: takes keypad commands on the rising edge of `finish`,
// starts the ALU, waits for its done pulse and publishes the result.
// One pending command is buffered while busy; further ones set `overrun`.
// Optional feature macro: KEY_SEQ_TIMEOUT_EN (bounded wait for alu_done,
// sticky `timeout`, RESULT forced to 16'hFFFF on expiry).
module key_alu_sequencer
    import key_alu_sequencer_pkg::*;
#(
    parameter int unsigned OP_W        = IC_N,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] SRC,
    input  logic [DATA_W-1:0] DST,
    input  logic [OP_W-1:0]   ALU_OP,
    input  logic              finish,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] RESULT,
    output logic              result_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    if (OP_W != IC_N || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("key_alu_sequencer: OP_W must equal IC_N and TIMEOUT_CYC must be 1..255");
    end

    seq_state_t state;
    logic       finish_q;
    logic       armed;
    logic       cmd_edge;

    logic              pend_valid;
    logic [DATA_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_b;
    logic [OP_W-1:0]   pend_op;
    logic              pend_load;
    logic              pend_clear;

`ifdef KEY_SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
`endif

    // `armed` is low for the first cycle after reset so a `finish` level that
    // is already high at release only primes finish_q instead of firing.
    assign cmd_edge = finish & ~finish_q & armed;

    // A command arriving in DONE with the slot empty is issued directly by
    // the FSM, so the slot only loads during ISSUE and WAIT.
    assign pend_load  = cmd_edge & ~pend_valid & ((state == ST_ISSUE) | (state == ST_WAIT));
    assign pend_clear = (state == ST_DONE) & pend_valid;

    assign busy = (state != ST_IDLE);

    key_cmd_slot #(
        .OP_W (OP_W)
    ) u_pending (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (pend_load),
        .clear (pend_clear),
        .a_in  (SRC),
        .b_in  (DST),
        .op_in (ALU_OP),
        .valid (pend_valid),
        .a     (pend_a),
        .b     (pend_b),
        .op    (pend_op)
    );

    // Sequencer FSM with registered ALU, result and flag outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            finish_q     <= 1'b0;
            armed        <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_start    <= 1'b0;
            RESULT       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef KEY_SEQ_TIMEOUT_EN
            timeout      <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            finish_q     <= finish;
            armed        <= 1'b1;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;

            if (cmd_edge && pend_valid && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_edge) begin
                        alu_a     <= SRC;
                        alu_b     <= DST;
                        alu_op    <= ALU_OP;
                        alu_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef KEY_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        RESULT       <= alu_result;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
`ifdef KEY_SEQ_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        timeout      <= 1'b1;
                        RESULT       <= TIMEOUT_RESULT;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    if (pend_valid) begin
                        alu_a     <= pend_a;
                        alu_b     <= pend_b;
                        alu_op    <= pend_op;
                        alu_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end else if (cmd_edge) begin
                        alu_a     <= SRC;
                        alu_b     <= DST;
                        alu_op    <= ALU_OP;
                        alu_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef KEY_SEQ_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule : key_alu_sequencer
